// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance, stall, branch/jump redirect,
// exception vectoring with target alignment checking, and a RUN/HALT state machine.
module pc_gen #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STEP       = 4,
  parameter logic [31:0] RESET_VEC  = 32'h0,
  parameter logic [31:0] EXC_VEC    = 32'h80,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic             i_exc,
  input  logic             i_halt,
  input  logic             i_resume,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_inc,
  output logic             o_flush,
  output logic             o_misalign,
  output logic             o_halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [WIDTH-1:0] RST_PC     = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // ALIGN_BITS = 0 yields an all-zero mask, which disables the check.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t           state, next_state;
  logic [WIDTH-1:0] next_pc;
  logic             next_flush, next_misalign;

  function automatic logic misaligned(input logic [WIDTH-1:0] target);
    return |(target & ALIGN_MASK);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      o_pc       <= RST_PC;
      o_pc_inc   <= RST_PC + STEP_W;
      o_flush    <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      state      <= next_state;
      o_pc       <= next_pc;
      o_pc_inc   <= next_pc + STEP_W;
      o_flush    <= next_flush;
      o_misalign <= next_misalign;
    end
  end

  assign o_halted = (state == HALT);

  // A misaligned redirect target is turned into an exception vector.
  always_comb begin
    next_state    = state;
    next_pc       = o_pc;
    next_flush    = 1'b0;
    next_misalign = 1'b0;
    unique case (state)
      RUN: begin
        if (i_exc) begin
          next_pc    = EXC_PC;
          next_flush = 1'b1;
        end else if (i_jump) begin
          next_flush = 1'b1;
          if (misaligned(i_jump_target)) begin
            next_pc       = EXC_PC;
            next_misalign = 1'b1;
          end else begin
            next_pc = i_jump_target;
          end
        end else if (i_branch_taken) begin
          next_flush = 1'b1;
          if (misaligned(i_branch_target)) begin
            next_pc       = EXC_PC;
            next_misalign = 1'b1;
          end else begin
            next_pc = i_branch_target;
          end
        end else if (i_halt) begin
          next_state = HALT;
        end else if (!i_stall) begin
          next_pc = o_pc + STEP_W;
        end
      end
      HALT: begin
        if (i_exc) begin
          next_pc    = EXC_PC;
          next_flush = 1'b1;
          next_state = RUN;
        end else if (i_resume) begin
          next_pc    = o_pc + STEP_W;
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven, scoreboarded bench for pc_gen (default 32-bit instance plus an
// 8-bit instance whose reset vector sits just below the wrap point).
module tb_pc_gen;

  typedef struct {
    string       name;
    logic        rst, stall, br, jmp, exc, halt, resume;
    logic [31:0] bt, jt;
    logic [31:0] epc, einc;
    logic        eflush, emis, ehalt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall = 1'b0, i_branch_taken = 1'b0, i_jump = 1'b0;
  logic        i_exc = 1'b0, i_halt = 1'b0, i_resume = 1'b0;
  logic [31:0] i_branch_target = '0, i_jump_target = '0;
  logic [31:0] o_pc, o_pc_inc;
  logic        o_flush, o_misalign, o_halted;

  logic        rst8 = 1'b1;
  logic [7:0]  pc8, pc_inc8;
  logic        flush8, misalign8, halted8;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
    .i_exc(i_exc), .i_halt(i_halt), .i_resume(i_resume),
    .o_pc(o_pc), .o_pc_inc(o_pc_inc), .o_flush(o_flush),
    .o_misalign(o_misalign), .o_halted(o_halted)
  );

  pc_gen #(.WIDTH(8), .RESET_VEC(32'h1F8)) dut8 (
    .clk(clk), .rst(rst8), .i_stall(1'b0), .i_branch_taken(1'b0),
    .i_branch_target(8'h00), .i_jump(1'b0), .i_jump_target(8'h00),
    .i_exc(1'b0), .i_halt(1'b0), .i_resume(1'b0),
    .o_pc(pc8), .o_pc_inc(pc_inc8), .o_flush(flush8),
    .o_misalign(misalign8), .o_halted(halted8)
  );

  function automatic vec_t mk(string n, logic r, logic st, logic b, logic j, logic e,
                              logic h, logic rs, logic [31:0] bt, logic [31:0] jt,
                              logic [31:0] epc, logic ef, logic em, logic eh);
    vec_t v;
    v.name = n; v.rst = r; v.stall = st; v.br = b; v.jmp = j; v.exc = e;
    v.halt = h; v.resume = rs; v.bt = bt; v.jt = jt;
    v.epc = epc; v.einc = epc + 32'd4; v.eflush = ef; v.emis = em; v.ehalt = eh;
    return v;
  endfunction

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; i_stall = v.stall; i_branch_taken = v.br; i_jump = v.jmp;
    i_exc = v.exc; i_halt = v.halt; i_resume = v.resume;
    i_branch_target = v.bt; i_jump_target = v.jt;
    sb.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".pc"},       o_pc,       e.epc);
    cmp({e.name, ".pc_inc"},   o_pc_inc,   e.einc);
    cmp({e.name, ".flush"},    {31'b0, o_flush},    {31'b0, e.eflush});
    cmp({e.name, ".misalign"}, {31'b0, o_misalign}, {31'b0, e.emis});
    cmp({e.name, ".halted"},   {31'b0, o_halted},   {31'b0, e.ehalt});
  endtask

  initial begin
    //            name           rst st br jm ex ha rs  br_tgt        jmp_tgt       exp_pc        fl ms hl
    tbl.push_back(mk("reset",     1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk("free1",     0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        0, 0, 0));
    tbl.push_back(mk("free2",     0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        0, 0, 0));
    tbl.push_back(mk("free3",     0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hC,        0, 0, 0));
    tbl.push_back(mk("free4",     0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10,       0, 0, 0));
    tbl.push_back(mk("stall1",    0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10,       0, 0, 0));
    tbl.push_back(mk("stall2",    0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10,       0, 0, 0));
    tbl.push_back(mk("unstall",   0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h14,       0, 0, 0));
    tbl.push_back(mk("jmp_br_st", 0, 1, 1, 1, 0, 0, 0, 32'h200,      32'h300,      32'h300,      1, 0, 0));
    tbl.push_back(mk("after_jmp", 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h304,      0, 0, 0));
    tbl.push_back(mk("jmp_mis",   0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h302,      32'h80,       1, 1, 0));
    tbl.push_back(mk("after_mis", 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h84,       0, 0, 0));
    tbl.push_back(mk("br_mis",    0, 0, 1, 0, 0, 0, 0, 32'h101,      32'h0,        32'h80,       1, 1, 0));
    tbl.push_back(mk("exc_jmp",   0, 0, 0, 1, 1, 0, 0, 32'h0,        32'h401,      32'h80,       1, 0, 0));
    tbl.push_back(mk("branch",    0, 0, 1, 0, 0, 0, 0, 32'h3C,       32'h0,        32'h3C,       1, 0, 0));
    tbl.push_back(mk("free5",     0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h40,       0, 0, 0));
    tbl.push_back(mk("halt",      0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h40,       0, 0, 1));
    tbl.push_back(mk("halt_br",   0, 0, 1, 0, 0, 0, 0, 32'h200,      32'h0,        32'h40,       0, 0, 1));
    tbl.push_back(mk("halt_jmp",  0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h500,      32'h40,       0, 0, 1));
    tbl.push_back(mk("resume",    0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h44,       0, 0, 0));
    tbl.push_back(mk("free6",     0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h48,       0, 0, 0));
    tbl.push_back(mk("halt2",     0, 1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h48,       0, 0, 1));
    tbl.push_back(mk("exc_res",   0, 0, 0, 0, 1, 0, 1, 32'h0,        32'h0,        32'h80,       1, 0, 0));
    tbl.push_back(mk("halt3",     0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h80,       0, 0, 1));
    tbl.push_back(mk("rst_halt",  1, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk("jmp_top",   0, 0, 0, 1, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0));
    tbl.push_back(mk("wrap32",    0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk("jmp_halt",  0, 0, 0, 1, 0, 1, 0, 32'h0,        32'h10,       32'h10,       1, 0, 0));
    tbl.push_back(mk("rst_exc",   1, 1, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput();
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    // 8-bit instance: reset vector truncates to 0xF8, then wraps past 0xFC.
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1;
    cmp("w8.rst.pc",     {24'b0, pc8},     32'hF8);
    cmp("w8.rst.pc_inc", {24'b0, pc_inc8}, 32'hFC);
    cmp("w8.rst.flush",  {31'b0, flush8 | misalign8 | halted8}, 32'h0);
    @(negedge clk); rst8 = 1'b0;
    @(posedge clk); #1;
    cmp("w8.fc.pc",      {24'b0, pc8},     32'hFC);
    cmp("w8.fc.pc_inc",  {24'b0, pc_inc8}, 32'h00);
    @(posedge clk); #1;
    cmp("w8.wrap.pc",     {24'b0, pc8},     32'h00);
    cmp("w8.wrap.pc_inc", {24'b0, pc_inc8}, 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
